kb_ascii_decoder: RTL and testbench

Parametrised keyboard decoding stage sitting between the PS/2 scan-code receiver and the UART transmitter. Tracks make/break/extended prefixes and Shift/Caps Lock state, translates make codes to case-correct ASCII (or passes raw make codes), and buffers results in an internal FIFO with a read-strobe interface. It replaces the direct scan-code-to-UART path, which had no modifier handling and no break-code filtering.

---
 rtl/kb_pkg.sv | 104 ++++++++++
 rtl/kb_fifo.sv | 55 +++++
 rtl/kb_ascii_decoder.sv | 143 ++++++++++++++
 tb/tb_kb_ascii_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Scan-code set 2 constants, decoder state encoding and the make-code to ASCII table.
// Pure definitions; no logic, no latency, no flow control.
// Consumers import kb_pkg::* and call kb_lookup() combinationally.
package kb_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

    // letter=1 selects case by Shift XOR Caps; otherwise Shift alone picks the glyph.
    typedef struct packed {
        logic       letter;
        logic [7:0] base;
        logic [7:0] shifted;
    } kb_glyph_t;

    function automatic kb_glyph_t kb_letter(input logic [7:0] lower);
        kb_glyph_t g;
        g.letter  = 1'b1;
        g.base    = lower;
        g.shifted = lower - 8'h20;
        return g;
    endfunction

    function automatic kb_glyph_t kb_sym(input logic [7:0] base, input logic [7:0] shifted);
        kb_glyph_t g;
        g.letter  = 1'b0;
        g.base    = base;
        g.shifted = shifted;
        return g;
    endfunction

    // Unmapped codes return base = shifted = 0x00 and are never pushed.
    function automatic kb_glyph_t kb_lookup(input logic [7:0] code);
        kb_glyph_t g;
        g = '0;
        case (code)
            8'h1C: g = kb_letter("a");
            8'h32: g = kb_letter("b");
            8'h21: g = kb_letter("c");
            8'h23: g = kb_letter("d");
            8'h24: g = kb_letter("e");
            8'h2B: g = kb_letter("f");
            8'h34: g = kb_letter("g");
            8'h33: g = kb_letter("h");
            8'h43: g = kb_letter("i");
            8'h3B: g = kb_letter("j");
            8'h42: g = kb_letter("k");
            8'h4B: g = kb_letter("l");
            8'h3A: g = kb_letter("m");
            8'h31: g = kb_letter("n");
            8'h44: g = kb_letter("o");
            8'h4D: g = kb_letter("p");
            8'h15: g = kb_letter("q");
            8'h2D: g = kb_letter("r");
            8'h1B: g = kb_letter("s");
            8'h2C: g = kb_letter("t");
            8'h3C: g = kb_letter("u");
            8'h2A: g = kb_letter("v");
            8'h1D: g = kb_letter("w");
            8'h22: g = kb_letter("x");
            8'h35: g = kb_letter("y");
            8'h1A: g = kb_letter("z");
            8'h0E: g = kb_sym(8'h60, 8'h7E);
            8'h16: g = kb_sym("1", "!");
            8'h1E: g = kb_sym("2", "@");
            8'h26: g = kb_sym("3", "#");
            8'h25: g = kb_sym("4", "$");
            8'h2E: g = kb_sym("5", "%");
            8'h36: g = kb_sym("6", "^");
            8'h3D: g = kb_sym("7", "&");
            8'h3E: g = kb_sym("8", "*");
            8'h46: g = kb_sym("9", "(");
            8'h45: g = kb_sym("0", ")");
            8'h4E: g = kb_sym("-", "_");
            8'h55: g = kb_sym("=", "+");
            8'h54: g = kb_sym("[", "{");
            8'h5B: g = kb_sym("]", "}");
            8'h5D: g = kb_sym(8'h5C, 8'h7C);
            8'h4C: g = kb_sym(";", ":");
            8'h52: g = kb_sym(8'h27, 8'h22);
            8'h41: g = kb_sym(",", "<");
            8'h49: g = kb_sym(".", ">");
            8'h4A: g = kb_sym("/", "?");
            8'h29: g = kb_sym(8'h20, 8'h20);
            8'h5A: g = kb_sym(8'h0D, 8'h0D);
            8'h66: g = kb_sym(8'h08, 8'h08);
            8'h0D: g = kb_sym(8'h09, 8'h09);
            8'h76: g = kb_sym(8'h1B, 8'h1B);
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/kb_fifo.sv
// Generic 8-bit synchronous first-word-fall-through FIFO, 2**FIFO_AW entries.
// Latency: a push is visible at head_dat/empty one cycle after its edge.
// Backpressure: push while full is accepted only with a same-cycle pop; pop while empty is ignored.
module kb_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       core_clk,
    input  logic       arst_n,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop_vld,
    output logic [7:0] head_dat,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop_ok  = pop_vld && !empty;
    assign push_ok = push_vld && (!full || pop_vld);

    // Forced to zero while empty so the head never exposes unwritten storage.
    assign head_dat = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/kb_ascii_decoder.sv
// PS/2 set-2 decoder: prefix/modifier tracking, ASCII (or raw) translation into a FWFT FIFO. Option: KB_CAPS_LOCK_EN.
// Latency: byte lands in the FIFO on the scan_valid edge; dout/empty reflect it one cycle later.
// Backpressure: none upstream; a push into a full FIFO without rd is dropped and sets sticky overflow.
module kb_ascii_decoder #(
    parameter int FIFO_AW  = 4,
    parameter int RAW_MODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       rd,
    input  logic       clr_ovf,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_on,
    output logic       caps_on
);

    import kb_pkg::*;

    kb_state_t state;
    kb_state_t state_nxt;
    logic      shift_l;
    logic      shift_l_nxt;
    logic      shift_r;
    logic      shift_r_nxt;
    logic      cand_vld;
    kb_glyph_t glyph;
    logic      upper_sel;
    logic [7:0] ascii_dat;
    logic [7:0] push_dat;
    logic      push_vld;

`ifdef KB_CAPS_LOCK_EN
    logic caps;
    logic caps_nxt;
`else
    logic caps;
    assign caps = 1'b0;
`endif

    assign shift_on = shift_l | shift_r;
    assign caps_on  = caps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_l <= shift_l_nxt;
            shift_r <= shift_r_nxt;
        end
    end

`ifdef KB_CAPS_LOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            caps <= 1'b0;
        end else begin
            caps <= caps_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
        cand_vld    = 1'b0;
`ifdef KB_CAPS_LOCK_EN
        caps_nxt    = caps;
`endif
        if (scan_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_nxt = ST_BRK;
                    end else if (scan_code == SC_CAPS) begin
`ifdef KB_CAPS_LOCK_EN
                        caps_nxt = ~caps;
`endif
                    end else begin
                        // Shift makes are still candidates: raw mode forwards them, the ASCII table maps them to 0.
                        if (scan_code == SC_LSHIFT) shift_l_nxt = 1'b1;
                        if (scan_code == SC_RSHIFT) shift_r_nxt = 1'b1;
                        cand_vld = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (scan_code == SC_LSHIFT) shift_l_nxt = 1'b0;
                    if (scan_code == SC_RSHIFT) shift_r_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    state_nxt = (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign glyph     = kb_lookup(scan_code);
    assign upper_sel = glyph.letter ? (shift_on ^ caps) : shift_on;
    assign ascii_dat = upper_sel ? glyph.shifted : glyph.base;
    assign push_dat  = (RAW_MODE != 0) ? scan_code : ascii_dat;
    assign push_vld  = cand_vld && ((RAW_MODE != 0) || (ascii_dat != 8'h00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_vld && full && !rd) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    kb_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .core_clk (clk),
        .arst_n   (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (rd),
        .head_dat (dout),
        .empty    (empty),
        .full     (full)
    );

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Bench for kb_ascii_decoder: three instances (ASCII/16, ASCII/4, RAW/16) share one scan stream,
// scored against a keyboard model built from character tables and per-instance queues.
module tb_kb_ascii_decoder;

`ifdef KB_CAPS_LOCK_EN
    localparam bit CAPS_EN = 1'b1;
`else
    localparam bit CAPS_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic [2:0] rd_v;
    logic [2:0] clr_v;
    logic [7:0] dout [3];
    logic [2:0] empty_v;
    logic [2:0] full_v;
    logic [2:0] ovf_v;
    logic [2:0] shift_v;
    logic [2:0] caps_v;

    int n_checks = 0;
    int n_pass   = 0;

    kb_ascii_decoder #(.FIFO_AW(4), .RAW_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd(rd_v[0]), .clr_ovf(clr_v[0]), .dout(dout[0]), .empty(empty_v[0]),
        .full(full_v[0]), .overflow(ovf_v[0]), .shift_on(shift_v[0]), .caps_on(caps_v[0]));
    kb_ascii_decoder #(.FIFO_AW(2), .RAW_MODE(0)) u_dut1 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd(rd_v[1]), .clr_ovf(clr_v[1]), .dout(dout[1]), .empty(empty_v[1]),
        .full(full_v[1]), .overflow(ovf_v[1]), .shift_on(shift_v[1]), .caps_on(caps_v[1]));
    kb_ascii_decoder #(.FIFO_AW(4), .RAW_MODE(1)) u_dut2 (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd(rd_v[2]), .clr_ovf(clr_v[2]), .dout(dout[2]), .empty(empty_v[2]),
        .full(full_v[2]), .overflow(ovf_v[2]), .shift_on(shift_v[2]), .caps_on(caps_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] lo_tab [256];
    logic [7:0] hi_tab [256];
    bit         let_tab [256];
    bit         known   [256];
    logic [7:0] key_list [$];

    int  dep  [3];
    bit  rawm [3];
    logic [7:0] mq [3][$];
    bit  m_ovf [3];
    bit  m_ext, m_brk, m_shl, m_shr, m_caps;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic add_key(input logic [7:0] code, input logic [7:0] lo, input logic [7:0] hi, input bit letter);
        lo_tab[code] = lo; hi_tab[code] = hi; let_tab[code] = letter; known[code] = 1'b1;
        key_list.push_back(code);
    endtask

    task automatic build_tables();
        string letters = "abcdefghijklmnopqrstuvwxyz";
        logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                       8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                       8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] sym_lo [20] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                                    8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
        logic [7:0] sym_hi [20] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                                    8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
        logic [7:0] sym_codes [20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                                       8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
        for (int i = 0; i < 256; i++) begin
            lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; let_tab[i] = 1'b0; known[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) add_key(let_codes[i], letters.getc(i), letters.getc(i) - 8'd32, 1'b1);
        for (int i = 0; i < 20; i++) add_key(sym_codes[i], sym_lo[i], sym_hi[i], 1'b0);
        add_key(8'h0E, 8'h60, 8'h7E, 1'b0);
        add_key(8'h29, 8'h20, 8'h20, 1'b0);
        add_key(8'h5A, 8'h0D, 8'h0D, 1'b0);
        add_key(8'h66, 8'h08, 8'h08, 1'b0);
        add_key(8'h0D, 8'h09, 8'h09, 1'b0);
        add_key(8'h76, 8'h1B, 8'h1B, 1'b0);
        dep  = '{16, 4, 16};
        rawm = '{1'b0, 1'b0, 1'b1};
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0;
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_ovf[i] = 0;
        end
    endtask

    // Applies one clock edge worth of behaviour using the currently driven inputs.
    task automatic model_step();
        bit         cand = 0;
        bit         sh   = m_shl | m_shr;
        bit         cp   = m_caps;
        logic [7:0] c    = scan_code;
        if (scan_valid) begin
            if (m_ext && m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (c == 8'hF0) m_brk = 1; else m_ext = 0;
            end else if (m_brk) begin
                if (c == 8'h12) m_shl = 0;
                if (c == 8'h59) m_shr = 0;
                m_brk = 0;
            end else if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'h58) begin
                if (CAPS_EN) m_caps = ~m_caps;
            end else begin
                cand = 1;
                if (c == 8'h12) m_shl = 1;
                if (c == 8'h59) m_shr = 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            bit         pv = 0;
            logic [7:0] pd = 8'h00;
            bit         was_full = (mq[i].size() == dep[i]);
            if (cand) begin
                if (rawm[i]) begin
                    pv = 1; pd = c;
                end else if (known[c]) begin
                    pd = (let_tab[c] ? (sh != cp) : sh) ? hi_tab[c] : lo_tab[c];
                    pv = 1;
                end
            end
            if (rd_v[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            if (pv && (!was_full || rd_v[i])) mq[i].push_back(pd);
            if (pv && was_full && !rd_v[i]) m_ovf[i] = 1;
            else if (clr_v[i]) m_ovf[i] = 0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("empty%0d", i), empty_v[i], mq[i].size() == 0);
            check_eq($sformatf("full%0d", i), full_v[i], mq[i].size() == dep[i]);
            check_eq($sformatf("overflow%0d", i), ovf_v[i], m_ovf[i]);
            check_eq($sformatf("shift_on%0d", i), shift_v[i], m_shl | m_shr);
            check_eq($sformatf("caps_on%0d", i), caps_v[i], m_caps);
            if (mq[i].size() > 0) check_eq($sformatf("dout%0d", i), dout[i], mq[i][0]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic v, input logic [7:0] c, input logic [2:0] r, input logic [2:0] cl);
        scan_valid = v; scan_code = c; rd_v = r; clr_v = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        scan_valid = 1'b0; rd_v = '0; clr_v = '0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] c);
        tick(1'b1, c, 3'b000, 3'b000);
    endtask

    task automatic do_reset();
        scan_valid = 1'b0; rd_v = '0; clr_v = '0;
        reset = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_dout%0d", i), dout[i], 8'h00);
            check_eq($sformatf("rst_empty%0d", i), empty_v[i], 1'b1);
            check_eq($sformatf("rst_full%0d", i), full_v[i], 1'b0);
            check_eq($sformatf("rst_ovf%0d", i), ovf_v[i], 1'b0);
            check_eq($sformatf("rst_shift%0d", i), shift_v[i], 1'b0);
            check_eq($sformatf("rst_caps%0d", i), caps_v[i], 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [7:0] pick_code();
        int r = $urandom_range(0, 19);
        case (r)
            0: return 8'h12;
            1: return 8'h59;
            2: return 8'h58;
            3: return 8'hE0;
            4, 5: return 8'hF0;
            6: return 8'($urandom_range(0, 255));
            default: return key_list[$urandom_range(0, key_list.size() - 1)];
        endcase
    endfunction

    initial begin
        reset = 1'b0; scan_valid = 1'b0; scan_code = 8'h00; rd_v = '0; clr_v = '0;
        build_tables();
        model_reset();
        @(negedge clk);
        do_reset();

        // make/break of 'a' yields one lower-case entry
        send(8'h1C);
        check_eq("a_first_nonempty", empty_v[0], 1'b0);
        check_eq("a_first_dout", dout[0], 8'h61);
        send(8'hF0); send(8'h1C);
        tick(1'b0, 8'h00, 3'b111, 3'b000);
        check_eq("a_break_nothing", empty_v[0], 1'b1);

        // shift held across two keys, then released
        do_reset();
        send(8'h12);
        check_eq("shift_held", shift_v[0], 1'b1);
        send(8'h1C); send(8'h16); send(8'hF0); send(8'h12); send(8'h1C);
        check_eq("shift_released", shift_v[0], 1'b0);
        check_eq("shift_A", dout[0], 8'h41);
        tick(1'b0, 8'h00, 3'b001, 3'b000);
        check_eq("shift_bang", dout[0], 8'h21);
        tick(1'b0, 8'h00, 3'b001, 3'b000);
        check_eq("unshift_a", dout[0], 8'h61);

        // caps lock toggle (behaviour depends on build option)
        do_reset();
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h12); send(8'h1C);
        check_eq("caps_state", caps_v[0], CAPS_EN);
        check_eq("caps_first", dout[0], CAPS_EN ? 8'h41 : 8'h61);
        tick(1'b0, 8'h00, 3'b001, 3'b000);
        check_eq("caps_second", dout[0], CAPS_EN ? 8'h61 : 8'h41);

        // extended keys are swallowed, FSM returns to idle
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
        check_eq("ext_space", dout[0], 8'h20);
        tick(1'b0, 8'h00, 3'b001, 3'b000);
        check_eq("ext_only_one", empty_v[0], 1'b1);
        send(8'h1C);
        check_eq("ext_idle_after", dout[0], 8'h61);

        // 4-deep FIFO: fill, overflow, push+pop while full, clear overflow
        do_reset();
        repeat (5) send(8'h1C);
        check_eq("small_full", full_v[1], 1'b1);
        check_eq("small_ovf", ovf_v[1], 1'b1);
        check_eq("small_head", dout[1], 8'h61);
        tick(1'b1, 8'h29, 3'b010, 3'b000);
        check_eq("small_full_pushpop", full_v[1], 1'b1);
        tick(1'b0, 8'h00, 3'b000, 3'b010);
        check_eq("small_ovf_clr", ovf_v[1], 1'b0);

        // raw mode forwards make codes including shift; reset drops pending prefix
        do_reset();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        check_eq("raw_first", dout[2], 8'h12);
        tick(1'b0, 8'h00, 3'b100, 3'b000);
        check_eq("raw_second", dout[2], 8'h1C);
        tick(1'b0, 8'h00, 3'b100, 3'b000);
        check_eq("raw_drained", empty_v[2], 1'b1);
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check_eq("raw_after_rst", dout[2], 8'h1C);
        check_eq("ascii_after_rst", dout[0], 8'h61);

        // randomized traffic against the model
        do_reset();
        for (int blk = 0; blk < 20; blk++) begin
            int rd_pct = $urandom_range(5, 90);
            for (int k = 0; k < 200; k++) begin
                logic [2:0] r, cl;
                for (int i = 0; i < 3; i++) begin
                    r[i]  = ($urandom_range(0, 99) < rd_pct);
                    cl[i] = ($urandom_range(0, 39) == 0);
                end
                if ($urandom_range(0, 499) == 0) do_reset();
                else tick($urandom_range(0, 2) != 0, pick_code(), r, cl);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
